// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down counter, programmable inclusive bound and step.
// Wrap or saturate at 0/limit; registered bound-event pulse evt.
// Ports: clk, rst (async, active-high), en, load_en, load, down, step,
//   limit, sat_mode -> count, evt, at_max, at_zero.
// Optional MOD_UPDOWN_COUNTER_STICKY_EN adds clr_flag in, ovf_flag out.
module mod_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
`ifdef MOD_UPDOWN_COUNTER_STICKY_EN
    input  logic              clr_flag,
    output logic              ovf_flag,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              evt,
    output logic              at_max,
    output logic              at_zero
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             evt_q, evt_d;

    // One extra bit so overflow past limit is visible in the compare.
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   lim_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] dn_diff;

    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign cnt_ext  = {1'b0, count_q};
    assign lim_ext  = {1'b0, limit};
    assign up_sum   = cnt_ext + step_ext;
    // Only consumed when step <= count, so no borrow can occur.
    assign dn_diff  = count_q - step_ext[WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        evt_d   = 1'b0;
        if (load_en) begin
            count_d = (load > limit) ? limit : load;
        end else if (en) begin
            if (count_q > limit) begin
                // limit was lowered under the count: pull back in range first.
                count_d = limit;
                evt_d   = 1'b1;
            end else if (!down) begin
                if (up_sum <= lim_ext) begin
                    count_d = up_sum[WIDTH-1:0];
                end else begin
                    count_d = sat_mode ? limit : '0;
                    evt_d   = 1'b1;
                end
            end else begin
                if (step_ext <= cnt_ext) begin
                    count_d = dn_diff;
                end else begin
                    count_d = sat_mode ? '0 : limit;
                    evt_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            evt_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
        end
    end

`ifdef MOD_UPDOWN_COUNTER_STICKY_EN
    logic ovf_q, ovf_d;

    // A new event outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (evt_d) begin
            ovf_d = 1'b1;
        end else if (clr_flag) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flag = ovf_q;
`endif

    assign count   = count_q;
    assign evt     = evt_q;
    assign at_max  = (count_q == limit);
    assign at_zero = (count_q == '0);

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised up/down counter with a programmable upper bound `limit` and a programmable step.
- Selectable wrap or saturate behaviour at the bounds.
- Registered bound-event pulse and optional sticky overflow flag.
- Next-generation general counter for testbench and datapath use. Sits behind the standard counter interface, extended with bound/step/mode signals.

Parameters:
- WIDTH, 8, count/load/limit width in bits (>= 2)
- STEP_W, 4, width of step input (1..WIDTH)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous active-high reset
- en  input  1  advance count by step this cycle
- load_en  input  1  synchronous load of load value
- load  input  WIDTH  load value
- down  input  1  1 = count down, 0 = count up
- step  input  STEP_W  increment/decrement amount, unsigned
- limit  input  WIDTH  inclusive upper bound; legal range 0..limit
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap
- count  output  WIDTH  current count, registered
- evt  output  1  one-cycle pulse: last update crossed or clamped a bound, registered
- at_max  output  1  combinational, count == limit
- at_zero  output  1  combinational, count == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port `clk`, reset port `rst`.
- Reset: count = 0, evt = 0 (and ovf_flag = 0 when present), immediately on rst rise, independent of clk. Held while rst = 1. Reset mid-count discards all state; first update happens on the first posedge after rst falls.
- Priority each posedge: rst > load_en > en > hold.
- Load:
  - count <= min(load, limit); evt <= 0.
  - load_en with en both high: load wins, no step applied.
- Hold: en = 0 and load_en = 0 -> count unchanged, evt <= 0.
- Step latency: 1 clock; count and evt update on the same edge.
- Arithmetic: all sums/differences computed at WIDTH+1 bits, unsigned; step zero-extended.
- Out-of-range clamp (limit lowered below count):
  - Applies to any enabled step, first check.
  - If count > limit: count <= limit, evt <= 1. Step ignored that cycle.
- Up (down = 0), nxt = count + step:
  - nxt <= limit: count <= nxt, evt <= 0.
  - nxt > limit, wrap: count <= 0, evt <= 1.
  - nxt > limit, saturate: count <= limit, evt <= 1.
- Down (down = 1), nxt = count - step:
  - step <= count: count <= nxt, evt <= 0.
  - step > count, wrap: count <= limit, evt <= 1.
  - step > count, saturate: count <= 0, evt <= 1.
- Saturate mode re-stepping at a bound:
  - Already at limit (up) or 0 (down), step != 0: count unchanged, evt <= 1 every such cycle.
- step = 0 with en: count unchanged, evt <= 0 (unless the out-of-range clamp applies).
- limit = 0:
  - count pinned at 0.
  - Any enabled step with step != 0 gives evt = 1 in both modes.
- evt is high for exactly one cycle per event. Back-to-back events hold evt high on consecutive cycles.
- at_max and at_zero follow count and limit combinationally. Both are 1 when limit = 0.

Optional Feature:
- Macro MOD_UPDOWN_COUNTER_STICKY_EN.
- Defined: adds ports `clr_flag` (input, 1) and `ovf_flag` (output, 1, registered).
  - ovf_flag <= 1 on any edge where evt is set to 1.
  - ovf_flag <= 0 on clr_flag.
  - Set and clear in the same cycle: set wins.
  - Reset value 0.
- Undefined: both ports absent; no other behaviour changes.

Test Plan:
- WIDTH=4, reset, then limit=9, step=3, up, wrap, en held -> count 0,3,6,9,0 with evt=1 only on the cycle count becomes 0. at_max=1 at 9.
- limit=9, step=4, up, sat_mode=1, from 0 -> count 4,8,9,9. evt=0,0,1,1.
- down, wrap, limit=12, step=5, load=3 then en -> count 3 then 12, evt=1. Next step -> 7, evt=0.
- load=14 with limit=10 and en=1 same cycle -> count 10, evt=0, no step applied. Then limit=6, en, up -> count 6, evt=1.
- Assert rst asynchronously mid-cycle while count=5 -> count 0 and evt 0 before the next posedge. Count resumes from 0+step on the first edge after rst falls.
- STICKY_EN: force one wrap -> ovf_flag=1 and persists after evt drops. clr_flag with a simultaneous wrap -> ovf_flag stays 1. clr_flag alone -> 0.
